// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//  Shared definitions for the FIFO read-side output stage.
//  Contents:
//    DATA_WIDTH_DEFAULT  default payload width for RAM data and stream data
//    fwft_level_t        occupancy of the 2-entry output buffer (0..2)
//    LVL_EMPTY/ONE/TWO   named occupancy values, also the buffer FSM states
//    fwft_has_room()     true while buffered + in-flight words leave space
//                        for one more RAM read
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DATA_WIDTH_DEFAULT = 8;

   typedef logic [1:0] fwft_level_t;

   localparam fwft_level_t LVL_EMPTY = 2'd0;
   localparam fwft_level_t LVL_ONE   = 2'd1;
   localparam fwft_level_t LVL_TWO   = 2'd2;

   // The buffer holds two words, so a new read may only be issued while the
   // words already buffered plus the one still coming back from RAM are < 2.
   function automatic logic fwft_has_room(input fwft_level_t lvl, input logic inflight);
      return ({1'b0, lvl} + {2'b00, inflight}) < 3'd2;
   endfunction

endpackage

// File: rtl/fifo_fwft_adapter_if.sv
// -----------------------------------------------------------------------------
// fifo_fwft_adapter_if
//  valid/ready stream carrying first-word-fall-through FIFO data.
//  Signals:
//    valid  producer -> consumer  data is valid
//    data   producer -> consumer  payload (DATA_WIDTH bits)
//    ready  consumer -> producer  consumer accepts data this cycle
//  Modports:
//    master  the producer (the adapter)
//    slave   the consumer
// -----------------------------------------------------------------------------
interface fifo_fwft_adapter_if #(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEFAULT
) ();

   logic                  valid;
   logic [DATA_WIDTH-1:0] data;
   logic                  ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/fwft_skid_buf.sv
// -----------------------------------------------------------------------------
// fwft_skid_buf
//  Two-entry head/tail output buffer. The head entry is always the word on
//  the output; the tail only holds a second word while the consumer stalls.
//  Ports:
//    clk        clock, all state on rising edge
//    rstn       asynchronous active-low reset
//    clear      synchronous clear of all buffered words
//    in_valid   a word is written this edge (caller guarantees space)
//    in_data    word to write
//    out_valid  head entry valid (level != 0)
//    out_data   head entry
//    out_ready  consumer takes the head entry this edge
//    level      number of buffered words (0..2)
// -----------------------------------------------------------------------------
module fwft_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clear,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output fwft_level_t           level
);

   fwft_level_t           level_q;
   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] tail_q;
   logic                  pop;

   assign pop = out_valid && out_ready;

   // Level FSM. head_q only changes when it is empty or being popped, which
   // keeps out_data stable for as long as the consumer stalls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         level_q <= LVL_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else if (clear) begin
         level_q <= LVL_EMPTY;
      end else begin
         case (level_q)
            LVL_EMPTY: begin
               if (in_valid) begin
                  head_q  <= in_data;
                  level_q <= LVL_ONE;
               end
            end
            LVL_ONE: begin
               if (in_valid && pop) begin
                  // Old head leaves, new word replaces it directly.
                  head_q <= in_data;
               end else if (in_valid) begin
                  tail_q  <= in_data;
                  level_q <= LVL_TWO;
               end else if (pop) begin
                  level_q <= LVL_EMPTY;
               end
            end
            LVL_TWO: begin
               if (pop) begin
                  head_q  <= tail_q;
                  level_q <= LVL_ONE;
               end
            end
            default: level_q <= LVL_EMPTY;
         endcase
      end
   end

   assign out_valid = (level_q != LVL_EMPTY);
   assign out_data  = head_q;
   assign level     = level_q;

   // Writing into a full buffer would silently lose a word.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(level_q == LVL_TWO && in_valid && !clear));

endmodule

// File: rtl/fifo_fwft_adapter.sv
// -----------------------------------------------------------------------------
// fifo_fwft_adapter
//  Read-side output stage of the FIFO. Issues reads into read_interface,
//  captures RAM data one cycle after each accepted read and presents it as a
//  first-word-fall-through valid/ready stream at one word per cycle.
//  Ports:
//    clk        clock, all state on rising edge
//    rstn       asynchronous active-low reset
//    empty      FIFO empty flag
//    read_en    read request (combinational)
//    mem_rdata  RAM read data, valid the cycle after an accepted read
//    flush      synchronous clear of buffered and in-flight data
//    m          output stream (master side)
//    level      words held in the output buffer (0..2)
// -----------------------------------------------------------------------------
module fifo_fwft_adapter
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  empty,
   output logic                  read_en,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  flush,
   fifo_fwft_adapter_if.master   m,
   output fwft_level_t           level
);

   logic inflight_q;
   logic inflight_d;
   logic pop;
   logic capture;

   assign pop = m.valid && m.ready;

   // A pop in the same cycle frees a slot, so read_en may depend on m.ready;
   // that path is what sustains one word per cycle with a full buffer.
   assign read_en = rstn && !empty && !flush && (fwft_has_room(level, inflight_q) || pop);

   // A word requested now comes back from RAM next cycle; flush drops it.
   assign inflight_d = read_en && !empty;
   assign capture    = inflight_q && !flush;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   fwft_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid_buf (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (flush),
      .in_valid  (capture),
      .in_data   (mem_rdata),
      .out_valid (m.valid),
      .out_data  (m.data),
      .out_ready (m.ready),
      .level     (level)
   );

   a_occupancy: assert property (@(posedge clk) disable iff (!rstn)
      ({1'b0, level} + {2'b00, inflight_q}) <= 3'd2);

endmodule

// File: tb/tb_fifo_fwft_adapter.sv
module tb_fifo_fwft_adapter;
   import fifo_pkg::*;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          flush = 1'b0;
   logic          read_en;
   logic          empty;
   logic [DW-1:0] mem_rdata = '0;
   fwft_level_t   level;

   fifo_fwft_adapter_if #(.DATA_WIDTH(DW)) s_if ();

   fifo_fwft_adapter #(.DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .empty     (empty),
      .read_en   (read_en),
      .mem_rdata (mem_rdata),
      .flush     (flush),
      .m         (s_if),
      .level     (level)
   );

   always #5 clk = ~clk;

   // RAM / read-pointer model: data returns one cycle after an accepted read.
   logic [DW-1:0] ram [0:1023];
   int            rd_ptr = 0;
   int            limit = 0;
   logic          force_empty = 1'b0;
   logic          sb_en = 1'b0;
   logic          log_en = 1'b1;
   logic [DW-1:0] exp_q [$];

   assign empty = force_empty || (rd_ptr >= limit);

   always @(posedge clk) begin
      if (read_en && !empty) begin
         mem_rdata <= ram[rd_ptr % 1024];
         if (sb_en) exp_q.push_back(ram[rd_ptr % 1024]);
         rd_ptr <= rd_ptr + 1;
      end
   end

   always @(posedge clk) begin
      if (log_en && s_if.valid && s_if.ready)
         $display("pop data=0x%02h level=%0d rd_ptr=%0d", s_if.data, level, rd_ptr);
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one cycle, landing on the falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic          prev_stall;
   logic [DW-1:0] prev_data;

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = DW'(i);
      for (int i = 0; i < 16; i++) ram[i] = DW'(i + 1);
      ram[16] = 8'hA1; ram[17] = 8'hA2; ram[18] = 8'hA3;
      ram[19] = 8'h5A;
      ram[20] = 8'hB0; ram[21] = 8'hB1; ram[22] = 8'hB2; ram[23] = 8'hB3; ram[24] = 8'hB4;

      // 1. reset with data available and consumer ready
      s_if.ready = 1'b1;
      limit      = 16;
      rstn       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_val("rst_read_en", read_en, 0);
      check_val("rst_m_valid", s_if.valid, 0);
      check_val("rst_m_data", s_if.data, 0);
      check_val("rst_level", level, 0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check_val("t1_read_en_after_rst", read_en, 1);
      check_val("t1_m_valid_first", s_if.valid, 0);

      // 2. streaming 0x01..0x10
      cyc();
      check_val("t2_m_valid_inflight", s_if.valid, 0);
      check_val("t2_read_en_inflight", read_en, 1);
      for (int i = 0; i < 16; i++) begin
         cyc();
         check_val("t2_m_valid", s_if.valid, 1);
         check_val("t2_m_data", s_if.data, i + 1);
         check_val("t2_level", level, 1);
      end
      cyc();
      check_val("t2_m_valid_end", s_if.valid, 0);
      check_val("t2_level_end", level, 0);
      check_val("t2_read_en_end", read_en, 0);

      // 3. backpressure after first word
      limit = 19;
      #1;
      check_val("t3_read_en_start", read_en, 1);
      cyc();
      check_val("t3_m_valid_d1", s_if.valid, 0);
      check_val("t3_read_en_d1", read_en, 1);
      cyc();
      check_val("t3_m_data_d2", s_if.data, 8'hA1);
      check_val("t3_level_d2", level, 1);
      s_if.ready = 1'b0;
      #1;
      check_val("t3_read_en_stall", read_en, 0);
      cyc();
      check_val("t3_level_full", level, 2);
      check_val("t3_m_data_hold1", s_if.data, 8'hA1);
      check_val("t3_read_en_full", read_en, 0);
      cyc();
      check_val("t3_m_valid_hold2", s_if.valid, 1);
      check_val("t3_m_data_hold2", s_if.data, 8'hA1);
      check_val("t3_level_hold2", level, 2);
      s_if.ready = 1'b1;
      #1;
      check_val("t3_read_en_pop_full", read_en, 1);
      cyc();
      check_val("t3_m_data_a2", s_if.data, 8'hA2);
      check_val("t3_level_a2", level, 1);
      cyc();
      check_val("t3_m_valid_a3", s_if.valid, 1);
      check_val("t3_m_data_a3", s_if.data, 8'hA3);
      cyc();
      check_val("t3_m_valid_end", s_if.valid, 0);

      // 4. single word then empty
      limit = 20;
      #1;
      check_val("t4_read_en_pulse", read_en, 1);
      cyc();
      check_val("t4_read_en_after", read_en, 0);
      check_val("t4_m_valid_inflight", s_if.valid, 0);
      cyc();
      check_val("t4_m_valid", s_if.valid, 1);
      check_val("t4_m_data", s_if.data, 8'h5A);
      check_val("t4_read_en_hold", read_en, 0);
      cyc();
      check_val("t4_m_valid_gone", s_if.valid, 0);
      check_val("t4_read_en_idle", read_en, 0);
      cyc();
      check_val("t4_read_count", rd_ptr, 20);

      // 5. flush with one word buffered and one in flight
      s_if.ready = 1'b0;
      limit      = 25;
      #1;
      check_val("t5_read_en_start", read_en, 1);
      cyc();
      check_val("t5_read_en_f1", read_en, 1);
      cyc();
      check_val("t5_m_data_b0", s_if.data, 8'hB0);
      check_val("t5_level_f2", level, 1);
      s_if.ready = 1'b1;
      flush      = 1'b1;
      #1;
      check_val("t5_read_en_flush", read_en, 0);
      check_val("t5_m_valid_flush", s_if.valid, 1);
      cyc();
      check_val("t5_m_valid_after", s_if.valid, 0);
      check_val("t5_level_after", level, 0);
      flush = 1'b0;
      #1;
      check_val("t5_read_en_resume", read_en, 1);
      cyc();
      check_val("t5_no_inflight_word", s_if.valid, 0);
      cyc();
      check_val("t5_m_data_b2", s_if.data, 8'hB2);
      cyc();
      check_val("t5_m_data_b3", s_if.data, 8'hB3);
      cyc();
      check_val("t5_m_data_b4", s_if.data, 8'hB4);
      cyc();
      check_val("t5_m_valid_end", s_if.valid, 0);

      // 6. random ready/empty with scoreboard
      log_en = 1'b0;
      for (int i = 0; i < 1024; i++) ram[i] = DW'($urandom);
      limit      = 1 << 30;
      sb_en      = 1'b1;
      prev_stall = 1'b0;
      prev_data  = '0;
      for (int k = 0; k < 10000; k++) begin
         force_empty = ($urandom_range(0, 3) == 0);
         s_if.ready  = ($urandom_range(0, 1) == 1);
         #1;
         if (prev_stall) begin
            check_val("t6_valid_stall", s_if.valid, 1);
            check_val("t6_data_stall", s_if.data, prev_data);
         end
         if (s_if.valid && s_if.ready) begin
            if (exp_q.size() == 0) check_val("t6_unexpected_pop", 1, 0);
            else check_val("t6_order", s_if.data, exp_q.pop_front());
         end
         prev_stall = s_if.valid && !s_if.ready;
         prev_data  = s_if.data;
         cyc();
      end
      force_empty = 1'b1;
      s_if.ready  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (s_if.valid) begin
            if (exp_q.size() == 0) check_val("t6_unexpected_pop", 1, 0);
            else check_val("t6_order_drain", s_if.data, exp_q.pop_front());
         end
         cyc();
      end
      check_val("t6_scoreboard_empty", exp_q.size(), 0);
      check_val("t6_m_valid_drained", s_if.valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
